// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: opcodes, FSM encoding,
// access-size codes and the opcode decoder.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LL  = 6'b110000;
  localparam logic [5:0] OP_SC  = 6'b111000;

  localparam logic        VALID      = 1'b1;
  localparam logic        INVALID    = 1'b0;
  localparam logic [31:0] ZERO       = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       is_mem;
    logic       is_load;   // lb/lbu/lh/lhu/lw/ll
    logic       is_store;  // sb/sh/sw/sc
    logic       is_ll;
    logic       is_sc;
    logic       sign;      // sign-extend the loaded byte/half
    logic [1:0] size;
  } op_dec_t;

  function automatic op_dec_t op_decode(input logic [5:0] op);
    op_dec_t d;
    d = op_dec_t'(8'h00);
    case (op)
      OP_LB:  begin d.is_mem = VALID; d.is_load = VALID; d.sign = VALID; d.size = SZ_BYTE; end
      OP_LBU: begin d.is_mem = VALID; d.is_load = VALID; d.size = SZ_BYTE; end
      OP_LH:  begin d.is_mem = VALID; d.is_load = VALID; d.sign = VALID; d.size = SZ_HALF; end
      OP_LHU: begin d.is_mem = VALID; d.is_load = VALID; d.size = SZ_HALF; end
      OP_LW:  begin d.is_mem = VALID; d.is_load = VALID; d.size = SZ_WORD; end
      OP_LL:  begin d.is_mem = VALID; d.is_load = VALID; d.is_ll = VALID; d.size = SZ_WORD; end
      OP_SB:  begin d.is_mem = VALID; d.is_store = VALID; d.size = SZ_BYTE; end
      OP_SH:  begin d.is_mem = VALID; d.is_store = VALID; d.size = SZ_HALF; end
      OP_SW:  begin d.is_mem = VALID; d.is_store = VALID; d.size = SZ_WORD; end
      OP_SC:  begin d.is_mem = VALID; d.is_store = VALID; d.is_sc = VALID; d.size = SZ_WORD; end
      default: d = op_dec_t'(8'h00);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: byte enables, store-data replication,
// load byte/half extraction with sign/zero extension, misalignment detect.
module mem_lane_align (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_fmt,
  output logic        misaligned
);
  import mem_access_unit_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half out of the read word.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = ld_data[7:0];
      2'b01:   byte_s = ld_data[15:8];
      2'b10:   byte_s = ld_data[23:16];
      default: byte_s = ld_data[31:24];
    endcase
    half_s = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
  end

  // Shape enables, write data and load result according to access size.
  always_comb begin
    be         = 4'b0000;
    wdata      = ZERO;
    ld_fmt     = ZERO;
    misaligned = INVALID;
    case (size)
      SZ_BYTE: begin
        be     = 4'b0001 << addr_lo;
        wdata  = {4{st_data[7:0]}};
        ld_fmt = sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
        ld_fmt     = sign_ext ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
      end
      SZ_WORD: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata      = st_data;
        ld_fmt     = ld_data;
      end
      default: begin
        be         = 4'b0000;
        wdata      = ZERO;
        ld_fmt     = ZERO;
        misaligned = INVALID;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline MEM stage: issues loads/stores over a req/ack port, stalls the
// pipeline while an access is outstanding, owns the LL/SC reservation bit.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64,
  parameter int LL_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [31:0]       regc_data,
  input  logic [REG_AW-1:0] regc_addr,
  input  logic              regc_write,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       reg_data,
  output logic [REG_AW-1:0] reg_addr,
  output logic              reg_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall_req,
  input  logic              llbit_clr,
  output logic              llbit,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              exc_buserr
);
  import mem_access_unit_pkg::*;

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buserr_q, buserr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              llbit_q, llbit_d;
  logic [ADDR_W-1:0] ll_addr_q, ll_addr_d;

  op_dec_t           dec_s;
  logic              active_s, misalign_s, sc_ok_s, go_s, issue_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s, ld_fmt_s;
  logic              lane_mis_s;

  mem_lane_align u_align (
    .addr_lo    (mem_addr_i[1:0]),
    .size       (dec_s.size),
    .sign_ext   (dec_s.sign),
    .st_data    (mem_data_i),
    .ld_data    (mem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .ld_fmt     (ld_fmt_s),
    .misaligned (lane_mis_s)
  );

  // Decode the op and decide whether an access may be launched from IDLE.
  always_comb begin
    active_s    = (rst != RST_ENABLE);
    dec_s       = op_decode(op);
    word_addr_s = {mem_addr_i[ADDR_W-1:2], 2'b00};
    misalign_s  = dec_s.is_mem & lane_mis_s;
    sc_ok_s     = (LL_EN == 0) ? VALID : llbit_q;
    go_s        = dec_s.is_mem & ~misalign_s & ~(dec_s.is_sc & ~sc_ok_s);
  end

  // FSM sequencing, timeout counting, read capture and reservation tracking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buserr_d  = buserr_q;
    rdata_d   = rdata_q;
    llbit_d   = llbit_q;
    ll_addr_d = ll_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          buserr_d = INVALID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          rdata_d = ld_fmt_s;
          state_d = ST_DONE;
          if (dec_s.is_ll) begin
            llbit_d   = VALID;
            ll_addr_d = word_addr_s;
          end else if (dec_s.is_store && (dec_s.is_sc || (word_addr_s == ll_addr_q))) begin
            llbit_d = INVALID;
          end else begin
            llbit_d = llbit_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          buserr_d = VALID;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // An external clear wins over any reservation set in the same cycle.
    if (llbit_clr || (LL_EN == 0)) begin
      llbit_d = INVALID;
    end else begin
      llbit_d = llbit_d;
    end
  end

  // Drive the memory port, stall, writeback and exception outputs.
  always_comb begin
    issue_s    = INVALID;
    stall_req  = INVALID;
    reg_addr   = regc_addr;
    reg_data   = regc_data;
    reg_write  = regc_write;
    exc_adel   = INVALID;
    exc_ades   = INVALID;
    exc_buserr = INVALID;
    if (!active_s) begin
      reg_data  = ZERO;
      reg_write = INVALID;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_s) begin
            issue_s   = VALID;
            stall_req = VALID;
            reg_write = INVALID;
          end else if (misalign_s) begin
            reg_write = INVALID;
            exc_adel  = dec_s.is_load;
            exc_ades  = dec_s.is_store;
          end else if (dec_s.is_sc) begin
            reg_data  = ZERO;
            reg_write = regc_write;
          end else begin
            reg_data  = regc_data;
            reg_write = regc_write;
          end
        end
        ST_BUSY: begin
          issue_s   = VALID;
          stall_req = VALID;
          reg_write = INVALID;
        end
        ST_DONE: begin
          reg_write  = regc_write & ~buserr_q;
          exc_buserr = buserr_q;
          if (dec_s.is_sc) begin
            reg_data = 32'h0000_0001;
          end else if (dec_s.is_load) begin
            reg_data = rdata_q;
          end else begin
            reg_data = regc_data;
          end
        end
        default: begin
          reg_write = INVALID;
        end
      endcase
    end
    mem_req = issue_s;
    if (issue_s) begin
      mem_we    = dec_s.is_store;
      mem_addr  = word_addr_s;
      mem_be    = be_s;
      mem_wdata = wdata_s;
    end else begin
      mem_we    = INVALID;
      mem_addr  = '0;
      mem_be    = 4'b0000;
      mem_wdata = ZERO;
    end
    llbit = llbit_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      buserr_q  <= INVALID;
      rdata_q   <= ZERO;
      llbit_q   <= INVALID;
      ll_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buserr_q  <= buserr_d;
      rdata_q   <= rdata_d;
      llbit_q   <= llbit_d;
      ll_addr_q <= ll_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads/stores, LL/SC, alignment,
// timeout and reset-during-access.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 8;

  logic        clk, rst;
  logic [5:0]  op;
  logic [31:0] regc_data, mem_data_i, mem_addr_i, mem_rdata;
  logic [4:0]  regc_addr;
  logic        regc_write, mem_ack, llbit_clr;
  logic [31:0] reg_data, mem_addr, mem_wdata;
  logic [4:0]  reg_addr;
  logic        reg_write, mem_req, mem_we, stall_req, llbit;
  logic [3:0]  mem_be;
  logic        exc_adel, exc_ades, exc_buserr;

  mem_access_unit #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(TO), .LL_EN(1)) dut (
    .clk(clk), .rst(rst), .op(op), .regc_data(regc_data), .regc_addr(regc_addr),
    .regc_write(regc_write), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .reg_data(reg_data), .reg_addr(reg_addr), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .llbit_clr(llbit_clr), .llbit(llbit),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_buserr(exc_buserr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        f_req, f_we;
  logic [31:0] f_addr, f_wdata;
  logic [3:0]  f_be;
  int          stalls;
  logic [31:0] o_data;
  logic        o_write, o_adel, o_ades, o_buserr, o_req, o_llbit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction, optionally ack in BUSY cycle ack_after (0 = never),
  // and capture first-cycle port values and the final (DONE or IDLE) outputs.
  task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                     input logic rw, input int ack_after, input logic [31:0] rd);
    @(posedge clk); #1;
    op = o; mem_addr_i = a; mem_data_i = d; regc_data = 32'hC0FF_EE00;
    regc_write = rw; regc_addr = 5'd9; mem_ack = 1'b0; mem_rdata = rd;
    #1;
    f_req = mem_req; f_we = mem_we; f_addr = mem_addr; f_be = mem_be; f_wdata = mem_wdata;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      if (!stall_req) break;
      stalls++;
      mem_ack = (ack_after != 0) && (k == ack_after);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
    end
    chk("run_bound", {31'd0, stall_req}, 32'd0);
    o_data = reg_data; o_write = reg_write; o_adel = exc_adel; o_ades = exc_ades;
    o_buserr = exc_buserr; o_req = mem_req; o_llbit = llbit;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; op = OP_LW; mem_addr_i = 32'h0000_0102; mem_data_i = 32'd0;
    regc_data = 32'd0; regc_addr = 5'd0; regc_write = 1'b1;
    mem_ack = 1'b0; mem_rdata = 32'd0; llbit_clr = 1'b0;
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_llbit", {31'd0, llbit}, 32'd0);
    chk("rst_adel", {31'd0, exc_adel}, 32'd0);
    chk("rst_buserr", {31'd0, exc_buserr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; op = 6'b001000;

    // non-memory op passes straight through
    run(6'b001000, 32'h104, 32'd0, 1'b1, 0, 32'd0);
    chk("alu_stalls", stalls, 32'd0);
    chk("alu_data", o_data, 32'hC0FF_EE00);
    chk("alu_write", {31'd0, o_write}, 32'd1);
    chk("alu_req", {31'd0, o_req}, 32'd0);
    chk("alu_regaddr", {27'd0, reg_addr}, 32'd9);

    // lw with ack in third BUSY cycle
    run(OP_LW, 32'h100, 32'd0, 1'b1, 3, 32'hDEAD_BEEF);
    chk("lw_req", {31'd0, f_req}, 32'd1);
    chk("lw_we", {31'd0, f_we}, 32'd0);
    chk("lw_addr", f_addr, 32'h100);
    chk("lw_be", {28'd0, f_be}, 32'hF);
    chk("lw_stalls", stalls, 32'd4);
    chk("lw_data", o_data, 32'hDEAD_BEEF);
    chk("lw_write", {31'd0, o_write}, 32'd1);
    chk("lw_done_req", {31'd0, o_req}, 32'd0);

    run(OP_LB, 32'h103, 32'd0, 1'b1, 1, 32'h80FF_7F01);
    chk("lb_stalls", stalls, 32'd2);
    chk("lb_be", {28'd0, f_be}, 32'h8);
    chk("lb_addr", f_addr, 32'h100);
    chk("lb_data", o_data, 32'hFFFF_FF80);
    run(OP_LBU, 32'h103, 32'd0, 1'b1, 1, 32'h80FF_7F01);
    chk("lbu_data", o_data, 32'h0000_0080);
    run(OP_LH, 32'h102, 32'd0, 1'b1, 1, 32'h80FF_7F01);
    chk("lh_data", o_data, 32'hFFFF_80FF);
    run(OP_LHU, 32'h100, 32'd0, 1'b1, 1, 32'h80FF_7F01);
    chk("lhu_data", o_data, 32'h0000_7F01);

    run(OP_SH, 32'h102, 32'h1234_ABCD, 1'b0, 2, 32'd0);
    chk("sh_we", {31'd0, f_we}, 32'd1);
    chk("sh_be", {28'd0, f_be}, 32'hC);
    chk("sh_wdata", f_wdata, 32'hABCD_ABCD);
    chk("sh_addr", f_addr, 32'h100);
    chk("sh_stalls", stalls, 32'd3);
    run(OP_SB, 32'h101, 32'h0000_00A5, 1'b0, 1, 32'd0);
    chk("sb_be", {28'd0, f_be}, 32'h2);
    chk("sb_wdata", f_wdata, 32'hA5A5_A5A5);

    // ll / sc success, then sc failure
    run(OP_LL, 32'h200, 32'd0, 1'b1, 1, 32'h0000_0077);
    chk("ll_data", o_data, 32'h0000_0077);
    chk("ll_llbit", {31'd0, o_llbit}, 32'd1);
    run(OP_SC, 32'h200, 32'd5, 1'b1, 1, 32'd0);
    chk("sc1_req", {31'd0, f_req}, 32'd1);
    chk("sc1_we", {31'd0, f_we}, 32'd1);
    chk("sc1_wdata", f_wdata, 32'd5);
    chk("sc1_stalls", stalls, 32'd2);
    chk("sc1_data", o_data, 32'd1);
    chk("sc1_llbit", {31'd0, o_llbit}, 32'd0);
    run(OP_SC, 32'h200, 32'd5, 1'b1, 1, 32'd0);
    chk("sc2_req", {31'd0, f_req}, 32'd0);
    chk("sc2_stalls", stalls, 32'd0);
    chk("sc2_data", o_data, 32'd0);
    chk("sc2_write", {31'd0, o_write}, 32'd1);

    // unrelated store keeps the reservation, matching store kills it
    run(OP_LL, 32'h200, 32'd0, 1'b1, 1, 32'd1);
    run(OP_SW, 32'h300, 32'd9, 1'b0, 1, 32'd0);
    chk("sw_other_llbit", {31'd0, o_llbit}, 32'd1);
    run(OP_SW, 32'h200, 32'd9, 1'b0, 1, 32'd0);
    chk("sw_same_llbit", {31'd0, o_llbit}, 32'd0);
    run(OP_SC, 32'h200, 32'd5, 1'b1, 1, 32'd0);
    chk("sc3_data", o_data, 32'd0);
    chk("sc3_req", {31'd0, f_req}, 32'd0);

    // external clear kills the reservation
    run(OP_LL, 32'h200, 32'd0, 1'b1, 1, 32'd1);
    @(posedge clk); #1;
    op = 6'b001000; llbit_clr = 1'b1;
    @(posedge clk); #1;
    llbit_clr = 1'b0;
    #1;
    chk("clr_llbit", {31'd0, llbit}, 32'd0);
    run(OP_SC, 32'h200, 32'd5, 1'b1, 1, 32'd0);
    chk("sc4_data", o_data, 32'd0);

    // misalignment
    run(OP_LW, 32'h102, 32'd0, 1'b1, 1, 32'd0);
    chk("adel_flag", {31'd0, o_adel}, 32'd1);
    chk("adel_req", {31'd0, f_req}, 32'd0);
    chk("adel_write", {31'd0, o_write}, 32'd0);
    chk("adel_stalls", stalls, 32'd0);
    run(OP_SH, 32'h101, 32'd0, 1'b0, 1, 32'd0);
    chk("ades_flag", {31'd0, o_ades}, 32'd1);
    chk("ades_adel", {31'd0, o_adel}, 32'd0);
    chk("ades_req", {31'd0, f_req}, 32'd0);

    // timeout
    run(OP_LW, 32'h100, 32'd0, 1'b1, 0, 32'd0);
    chk("to_stalls", stalls, TO + 1);
    chk("to_buserr", {31'd0, o_buserr}, 32'd1);
    chk("to_write", {31'd0, o_write}, 32'd0);
    run(6'b001000, 32'd0, 32'd0, 1'b1, 0, 32'd0);
    chk("to_idle_buserr", {31'd0, o_buserr}, 32'd0);
    run(OP_LL, 32'h400, 32'd0, 1'b1, 0, 32'd0);
    chk("to_ll_buserr", {31'd0, o_buserr}, 32'd1);
    chk("to_ll_llbit", {31'd0, o_llbit}, 32'd0);

    // reset while BUSY
    @(posedge clk); #1;
    op = OP_LW; mem_addr_i = 32'h100; regc_write = 1'b1;
    #1;
    chk("rb_req_before", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rb_req", {31'd0, mem_req}, 32'd0);
    chk("rb_stall", {31'd0, stall_req}, 32'd0);
    op = 6'b001000;
    @(posedge clk); #1;
    rst = 1'b1;
    run(OP_LW, 32'h100, 32'd0, 1'b1, 1, 32'h1234_5678);
    chk("rb_after_stalls", stalls, 32'd2);
    chk("rb_after_data", o_data, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
